fifo_word_packer: RTL and testbench

- Read-side consumer for the 8-bit asynchronous FIFO; runs entirely in the FIFO read clock domain.
- Pops bytes by driving the FIFO's rd_en, watching is_empty and capturing the FIFO's registered byte output.
- Packs BYTES consecutive bytes into one wide word, presented on a valid/ready handshake.
- Flushes a partial word, with a byte-keep mask, if the FIFO stays empty too long.

---
 rtl/fifo_word_packer.sv | 141 ++++++++++++++
 tb/tb_fifo_word_packer.sv | 205 ++++++++++++++++++++
 2 files changed

// File: rtl/fifo_word_packer.sv
`default_nettype none
// ============================================================================
// Module   : fifo_word_packer
// Function : Pops bytes from an 8-bit FIFO read port and packs BYTES of them
//            into one word on a valid/ready handshake. After TIMEOUT idle
//            cycles, a partial word is flushed with a byte-keep mask.
//            Optional macro WORD_PARITY_EN adds the per-lane parity port
//            word_par.
// Revision : 1.0 - initial release
// ============================================================================
module fifo_word_packer #(
  parameter int BYTES   = 4,
  parameter int TIMEOUT = 15
) (
  input  logic                 clk,
  input  logic                 rst,
  output logic                 rd_en,
  input  logic                 is_empty,
  input  logic [7:0]           fifo_data,
  output logic [8*BYTES-1:0]   word_out,
  output logic [BYTES-1:0]     word_keep,
  output logic                 word_valid,
`ifdef WORD_PARITY_EN
  output logic [BYTES-1:0]     word_par,
`endif
  input  logic                 word_ready
);

  localparam int              c_CW       = $clog2(BYTES + 1);
  localparam logic [c_CW-1:0] c_FULL     = c_CW'(BYTES);
  localparam logic [c_CW-1:0] c_LAST     = c_CW'(BYTES - 1);
  localparam logic [c_CW-1:0] c_ONE      = c_CW'(1);
  localparam logic [7:0]      c_TMO_LAST = 8'(TIMEOUT - 1);

  typedef enum logic [0:0] {
    ACCUM = 1'b0,
    OUT   = 1'b1
  } state_t;

  state_t                r_state;
  state_t                w_state_nxt;
  logic [c_CW-1:0]       r_filled;
  logic [c_CW-1:0]       r_issued;
  logic                  r_cap_pend;
  logic [7:0]            r_timer;
  logic [8*BYTES-1:0]    r_word_out;
  logic [BYTES-1:0]      r_word_keep;

  logic                  w_count;
  logic                  w_flush;
  logic                  w_cap_last;
  logic                  w_accept;

  // The timer only runs while a partial word waits with no byte in flight.
  assign w_count    = (r_state == ACCUM) && (r_filled != '0) &&
                      (r_filled < c_FULL) && !r_cap_pend;
  assign w_flush    = w_count && (r_timer == c_TMO_LAST);
  assign w_cap_last = r_cap_pend && (r_filled == c_LAST);
  assign w_accept   = (r_state == OUT) && word_ready;

  // A flush that coincides with fresh FIFO data takes priority over the pop.
  assign rd_en      = (r_state == ACCUM) && !is_empty &&
                      (r_issued < c_FULL) && !w_flush;
  assign word_valid = (r_state == OUT);
  assign word_out   = r_word_out;
  assign word_keep  = r_word_keep;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state <= ACCUM;
    end else begin
      r_state <= w_state_nxt;
    end
  end

  always_comb begin
    w_state_nxt = r_state;
    case (r_state)
      ACCUM:   if (w_cap_last || w_flush) w_state_nxt = OUT;
      OUT:     if (word_ready)            w_state_nxt = ACCUM;
      default: w_state_nxt = ACCUM;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_filled    <= '0;
      r_issued    <= '0;
      r_cap_pend  <= 1'b0;
      r_timer     <= '0;
      r_word_out  <= '0;
      r_word_keep <= '0;
    end else if (w_accept) begin
      r_filled    <= '0;
      r_issued    <= '0;
      r_cap_pend  <= 1'b0;
      r_timer     <= '0;
      r_word_out  <= '0;
      r_word_keep <= '0;
    end else begin
      r_cap_pend <= rd_en;
      if (rd_en) begin
        r_issued <= r_issued + c_ONE;
      end
      if (r_cap_pend) begin
        for (int i = 0; i < BYTES; i++) begin
          if (r_filled == c_CW'(i)) begin
            r_word_out[i*8 +: 8] <= fifo_data;
            r_word_keep[i]       <= 1'b1;
          end
        end
        r_filled <= r_filled + c_ONE;
        r_timer  <= '0;
      end else if (w_count) begin
        r_timer <= r_timer + 8'd1;
      end
    end
  end

`ifdef WORD_PARITY_EN
  logic [BYTES-1:0] r_word_par;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_word_par <= '0;
    end else if (w_accept) begin
      r_word_par <= '0;
    end else if (r_cap_pend) begin
      for (int i = 0; i < BYTES; i++) begin
        if (r_filled == c_CW'(i)) begin
          r_word_par[i] <= ^fifo_data;
        end
      end
    end
  end

  assign word_par = r_word_par;
`endif

endmodule
`default_nettype wire

// File: tb/tb_fifo_word_packer.sv
`default_nettype none
// ============================================================================
// Module   : tb_fifo_word_packer
// Function : Directed self-checking bench for fifo_word_packer (BYTES=4,
//            TIMEOUT=15) using a queue-based model of the FIFO read port.
// Revision : 1.0 - initial release
// ============================================================================
module tb_fifo_word_packer;

  localparam int BYTES   = 4;
  localparam int TIMEOUT = 15;

  logic                clk;
  logic                rst;
  logic                rd_en;
  logic                is_empty;
  logic [7:0]          fifo_data;
  logic [8*BYTES-1:0]  word_out;
  logic [BYTES-1:0]    word_keep;
  logic                word_valid;
  logic                word_ready;
`ifdef WORD_PARITY_EN
  logic [BYTES-1:0]    word_par;
`endif

  int n_cmp = 0;
  int n_err = 0;
  logic [7:0] q[$];

  fifo_word_packer #(.BYTES(BYTES), .TIMEOUT(TIMEOUT)) dut (
    .clk        (clk),
    .rst        (rst),
    .rd_en      (rd_en),
    .is_empty   (is_empty),
    .fifo_data  (fifo_data),
    .word_out   (word_out),
    .word_keep  (word_keep),
    .word_valid (word_valid),
`ifdef WORD_PARITY_EN
    .word_par   (word_par),
`endif
    .word_ready (word_ready)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // FIFO read-side model: registered data, one byte per accepted pop.
  always @(posedge clk) begin
    if (rd_en && q.size() > 0) begin
      fifo_data <= q[0];
      void'(q.pop_front());
      is_empty  <= (q.size() == 0);
    end
  end

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  task automatic push(input logic [7:0] b);
    q.push_back(b);
    is_empty = 1'b0;
  endtask

  task automatic step();
    @(negedge clk);
    #1;
  endtask

  // Advance until word_valid, counting samples and cycles with rd_en high.
  task automatic wait_valid(output int cyc, output int pops);
    cyc  = 0;
    pops = 0;
    while (!word_valid && cyc < 200) begin
      if (rd_en) pops++;
      step();
      cyc++;
    end
    check("wait_valid", {63'd0, word_valid}, 64'd1);
  endtask

  int cyc, pops, bad;

  initial begin
    rst        = 1'b1;
    is_empty   = 1'b1;
    fifo_data  = 8'h00;
    word_ready = 1'b1;
    step();
    check("rst_valid", {63'd0, word_valid}, 64'd0);
    check("rst_keep",  {60'd0, word_keep}, 64'd0);
    check("rst_word",  {32'd0, word_out}, 64'd0);
    check("rst_rd_en", {63'd0, rd_en}, 64'd0);
    rst = 1'b0;

    bad = 0;
    for (int i = 0; i < 100; i++) begin
      if (rd_en || word_valid) bad++;
      step();
    end
    check("empty_idle", bad, 0);

    for (int i = 1; i <= 8; i++) push(8'(i));
    #1;
    wait_valid(cyc, pops);
    check("w1_latency", cyc, 5);
    check("w1_pops", pops, 4);
    check("w1_word", {32'd0, word_out}, 64'h04030201);
    check("w1_keep", {60'd0, word_keep}, 64'hF);
    check("w1_no_pop", {63'd0, rd_en}, 64'd0);

    step();
    word_ready = 1'b0;
    wait_valid(cyc, pops);
    check("w2_pops", pops, 4);
    check("w2_word", {32'd0, word_out}, 64'h08070605);

    push(8'h55);
    push(8'h66);
    #1;
    bad = 0;
    for (int i = 0; i < 10; i++) begin
      if (word_out !== 32'h08070605 || rd_en || !word_valid) bad++;
      step();
    end
    check("stall_stable", bad, 0);
    word_ready = 1'b1;
    #1;
    check("acc_cycle_rd_en", {63'd0, rd_en}, 64'd0);
    check("acc_cycle_valid", {63'd0, word_valid}, 64'd1);
    step();
    check("post_acc_valid", {63'd0, word_valid}, 64'd0);
    check("post_acc_word", {32'd0, word_out}, 64'd0);
    check("post_acc_keep", {60'd0, word_keep}, 64'd0);
    check("post_acc_rd_en", {63'd0, rd_en}, 64'd1);

    repeat (5) step();
    check("partial_keep", {60'd0, word_keep}, 64'h3);
    check("partial_word", {32'd0, word_out}, 64'h6655);
    rst = 1'b1;
    #1;
    check("async_rst_valid", {63'd0, word_valid}, 64'd0);
    check("async_rst_keep", {60'd0, word_keep}, 64'd0);
    check("async_rst_word", {32'd0, word_out}, 64'd0);
    #1;
    rst = 1'b0;
    #1;
    push(8'h11); push(8'h22); push(8'h33); push(8'h44);
    #1;
    wait_valid(cyc, pops);
    check("after_rst_word", {32'd0, word_out}, 64'h44332211);
    check("after_rst_keep", {60'd0, word_keep}, 64'hF);

    step();
    push(8'h01); push(8'h03); push(8'h07); push(8'hFF);
    #1;
    wait_valid(cyc, pops);
    check("par_word", {32'd0, word_out}, 64'hFF070301);
`ifdef WORD_PARITY_EN
    check("par_bits", {60'd0, word_par}, 64'b0101);
`endif

    step();
    push(8'hAA);
    push(8'hBB);
    bad = 0;
    for (int n = 1; n <= 17; n++) begin
      step();
      if (word_valid) bad++;
    end
    check("flush_early", bad, 0);
    push(8'hCC);
    #1;
    check("race_rd_en", {63'd0, rd_en}, 64'd0);
    step();
    check("flush_valid", {63'd0, word_valid}, 64'd1);
    check("flush_word", {32'd0, word_out}, 64'h0000BBAA);
    check("flush_keep", {60'd0, word_keep}, 64'h3);

    step();
    wait_valid(cyc, pops);
    check("single_latency", cyc, 17);
    check("single_pops", pops, 1);
    check("single_word", {32'd0, word_out}, 64'h000000CC);
    check("single_keep", {60'd0, word_keep}, 64'h1);

    step();
    bad = 0;
    for (int i = 0; i < 30; i++) begin
      if (rd_en || word_valid) bad++;
      step();
    end
    check("final_idle", bad, 0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
`default_nettype wire
